// File: rtl/note_scheduler.sv
// Polyphony controller: allocates incoming notes to the lowest idle voice, tracks
// per-voice busy state, and sequences/mixes one sample from every voice per request.
module note_scheduler #(
    parameter int NUM_VOICES = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play_enable,
    input  logic [5:0]                 note_in,
    input  logic [5:0]                 duration_in,
    input  logic                       note_valid,
    output logic                       note_ready,
    output logic [NUM_VOICES-1:0]      voice_load,
    output logic [5:0]                 voice_note,
    output logic [5:0]                 voice_duration,
    input  logic [NUM_VOICES-1:0]      voice_done,
    output logic [NUM_VOICES-1:0]      voice_busy,
    input  logic                       generate_next_sample,
    output logic                       voice_gen_next,
    input  logic [16*NUM_VOICES-1:0]   voice_sample,
    input  logic [NUM_VOICES-1:0]      voice_sample_ready,
    output logic [15:0]                sample_out,
    output logic                       new_sample_ready,
    output logic                       overrun
);

    localparam int SUM_W = 16 + $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SUM     = 2'd2
    } mix_state_t;

    mix_state_t state_r, state_next_s;

    logic [NUM_VOICES-1:0] busy_r, armed_r, load_r, captured_r;
    logic [NUM_VOICES-1:0] alloc_s, load_mask_s, release_s, arm_set_s;
    logic [NUM_VOICES-1:0] ready_now_s, captured_next_s;
    logic [5:0]            note_r, duration_r;
    logic [15:0]           latched_r [NUM_VOICES];
    logic [15:0]           eff_s     [NUM_VOICES];
    logic signed [SUM_W-1:0] sum_s;
    logic [15:0]           sample_r;
    logic                  accept_s, sample_en_s, all_captured_s;
    logic                  gen_next_r, new_sample_r, overrun_r;

    // Clamp a widened signed sum into the 16-bit signed range.
    function automatic logic [15:0] saturate(input logic signed [SUM_W-1:0] value);
        logic [SUM_W-16:0] top_bits;
        top_bits = value[SUM_W-1:15];
        if ((&top_bits) || (~|top_bits)) begin
            saturate = value[15:0];
        end else if (value[SUM_W-1]) begin
            saturate = 16'h8000;
        end else begin
            saturate = 16'h7FFF;
        end
    endfunction

    assign note_ready  = play_enable & ~(&busy_r);
    assign accept_s    = note_valid & note_ready;
    assign load_mask_s = alloc_s & {NUM_VOICES{accept_s}};
    assign arm_set_s   = busy_r & ~voice_done;
    // A voice is released only after done was seen low at least once since its load.
    assign release_s   = busy_r & armed_r & voice_done;

    // Priority pick of the lowest-index idle voice.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        alloc_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            alloc_s[i] = ~busy_r[i] & ~seen;
            seen       = seen | ~busy_r[i];
        end
    end

    // Voice allocation, load strobes, shared note bus and busy/armed tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r     <= '0;
            armed_r    <= '0;
            load_r     <= '0;
            note_r     <= 6'd0;
            duration_r <= 6'd0;
        end else begin
            load_r  <= load_mask_s;
            busy_r  <= (busy_r & ~release_s) | load_mask_s;
            armed_r <= (armed_r | arm_set_s) & ~release_s & ~load_mask_s;
            if (accept_s) begin
                note_r     <= note_in;
                duration_r <= duration_in;
            end
        end
    end

    // The broadcast cycle itself is skipped so voices see the request before we sample.
    assign sample_en_s     = (state_r == ST_COLLECT) & ~gen_next_r;
    assign ready_now_s     = voice_sample_ready & ~captured_r & {NUM_VOICES{sample_en_s}};
    assign captured_next_s = captured_r | ready_now_s;
    assign all_captured_s  = sample_en_s & (&captured_next_s);

    // Sum already-latched samples plus any arriving this cycle, so the result can
    // be registered on the same edge that completes collection.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            eff_s[i] = captured_r[i] ? latched_r[i] : voice_sample[16*i +: 16];
            sum_s    = sum_s + SUM_W'($signed(eff_s[i]));
        end
    end

    // Mix FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Mix FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (generate_next_sample) begin
                    state_next_s = ST_COLLECT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (all_captured_s) begin
                    state_next_s = ST_SUM;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_SUM:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Mix datapath: request broadcast, sample capture, result and overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            captured_r   <= '0;
            gen_next_r   <= 1'b0;
            new_sample_r <= 1'b0;
            sample_r     <= 16'd0;
            overrun_r    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                latched_r[i] <= 16'd0;
            end
        end else begin
            gen_next_r   <= 1'b0;
            new_sample_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (generate_next_sample) begin
                        captured_r <= '0;
                        gen_next_r <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (ready_now_s[i]) begin
                            latched_r[i] <= voice_sample[16*i +: 16];
                        end
                    end
                    captured_r <= captured_next_s;
                    if (all_captured_s) begin
                        sample_r     <= saturate(sum_s);
                        new_sample_r <= 1'b1;
                    end
                end
                default: begin
                    captured_r <= captured_r;
                end
            endcase
            if (generate_next_sample && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign voice_load       = load_r;
    assign voice_note       = note_r;
    assign voice_duration   = duration_r;
    assign voice_busy       = busy_r;
    assign voice_gen_next   = gen_next_r;
    assign sample_out       = sample_r;
    assign new_sample_ready = new_sample_r;
    assign overrun          = overrun_r;

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Polyphony controller that sits between the song/chord sequencer and a bank of `NUM_VOICES` note_player instances. It hands each incoming note to the lowest-index idle voice and tracks per-voice busy state from `done_with_note`. It also sequences the codec sample request across all voices, collects one sample from each, and emits a single saturated mixed sample with a ready pulse.

## Interface
Parameters:
- `NUM_VOICES`, default 3: number of note_player voices driven; legal range 1–8.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `play_enable` in 1: when low, no new allocations are made; mixing continues.
- `note_in` in 6: note code to play.
- `duration_in` in 6: duration in beats.
- `note_valid` in 1: a note request is present.
- `note_ready` out 1: the request is accepted this cycle (valid & ready).
- `voice_load` out NUM_VOICES: one-hot, one-cycle load strobe per voice.
- `voice_note` out 6: registered note bus shared by all voices.
- `voice_duration` out 6: registered duration bus shared by all voices.
- `voice_done` in NUM_VOICES: per-voice `done_with_note`.
- `voice_busy` out NUM_VOICES: per-voice busy flags.
- `generate_next_sample` in 1: codec sample request pulse.
- `voice_gen_next` out 1: request broadcast to all voices.
- `voice_sample` in 16*NUM_VOICES: signed samples; voice i occupies bits [16i+15:16i].
- `voice_sample_ready` in NUM_VOICES: per-voice sample-ready levels.
- `sample_out` out 16: signed mixed sample.
- `new_sample_ready` out 1: one-cycle pulse when `sample_out` updates.
- `overrun` out 1: sticky; set when a request arrives while a mix is still in progress.

## Operation
- **Allocation.** `note_ready = play_enable & (voice_busy != all-ones)`, combinational.
  - On accept, the target is the lowest index i with `voice_busy[i]==0`.
  - Next cycle: `voice_load[i]=1`, `voice_note`/`voice_duration` hold the accepted values, `voice_busy[i]` is set, and `armed[i]` is cleared.
- **Busy release.** `done_with_note` lags the load strobe, so per-voice logic works as follows:
  - `armed[i]` sets when `voice_busy[i]` is high and `voice_done[i]` is low.
  - `voice_busy[i]` clears the first cycle `armed[i]` and `voice_done[i]` are both high.
  - A voice whose done never drops stays busy; this is intended.
- **Simultaneous events.** A release and an accept in the same cycle are allowed. The released voice is not eligible until the next cycle.
- **Mix FSM** has states IDLE, COLLECT, SUM.
  - IDLE: on `generate_next_sample`, clear the captured mask, pulse `voice_gen_next`, and go to COLLECT.
  - COLLECT: from the cycle after the broadcast onward, latch `voice_sample[i]` the first cycle `voice_sample_ready[i]` is high and set `captured[i]`. When all bits are set, go to SUM.
  - SUM: take the signed sum of the latched samples, computed at width 16+clog2(NUM_VOICES). Saturate to [-32768, 32767], register the result into `sample_out`, pulse `new_sample_ready`, and return to IDLE.
- **Overrun.** A `generate_next_sample` pulse seen in COLLECT or SUM is dropped and sets `overrun`.
- **Idle voices.** Idle voices are still mixed; their outputs are expected to be 0 because their step size is 0.

## Timing
- Reset values:
  - `voice_busy`, armed, captured all 0.
  - `voice_load` = 0, `voice_gen_next` = 0, `new_sample_ready` = 0.
  - `voice_note` = 0, `voice_duration` = 0.
  - `sample_out` = 0, `overrun` = 0.
  - FSM in IDLE.
- Reset mid-note or mid-mix aborts immediately; nothing is pending afterwards.
- Accept in cycle t: `voice_load` high in t+1 only; `voice_busy` high from t+1.
- `generate_next_sample` in cycle t: `voice_gen_next` high in t+1.
- Collection: sampling of ready lines starts in t+2. If all voices are ready in t+2, SUM is entered in t+3 and `new_sample_ready` pulses in t+3. Minimum request-to-sample latency is 3 cycles.
- All outputs except `note_ready` are registered.

## Test plan
- **Reset and allocation order.** Assert reset mid-operation, then present 3 notes back to back with all voices idle and done high. Required: `voice_load` = 001, 010, 100 in consecutive cycles; `note_ready` drops after the third accept; `voice_busy`=111.
- **Release and reuse.** Voice 1 done goes low then high. Required: `voice_busy[1]` clears one cycle after done rises. A pending note (note_in=6'd20, duration_in=6'd12) is then accepted into voice 1 with `voice_note`=20 and `voice_duration`=12.
- **Release-before-arm guard.** Hold `voice_done[0]` high throughout after a load. Required: voice 0 stays busy; no reuse occurs.
- **Mix arithmetic.** Samples 1000, -300, 250 with all ready in t+2. Required: `sample_out`=950, `new_sample_ready` pulse in t+3.
- **Saturation and staggered ready.** Samples 30000, 30000, -100, with ready for voice 2 arriving 5 cycles late. Required: single pulse after the last ready, `sample_out`=32767. With samples -20000, -20000, 0, required `sample_out`=-32768.
- **Overrun and pause.** Send a second `generate_next_sample` during COLLECT. Required: `overrun`=1 and sticky, only one `new_sample_ready` pulse. With `play_enable`=0, required `note_ready`=0 and no `voice_load`.
